// File: rtl/axi_slave_write_receiver.sv
// axi_slave_write_receiver: accepts one AXI3 write burst, forwards each beat with its address to the engine, returns one B response.
module axi_slave_write_receiver #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      awid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [3:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic                      wid,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic                      bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic                      eng_en,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [ADDR_WIDTH-1:0]     beat_addr,
  output logic [DATA_WIDTH-1:0]     beat_data,
  output logic [DATA_WIDTH/8-1:0]   beat_strb,
  output logic                      beat_last,
  input  logic                      beat_err,
  output logic                      busy
);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH/8);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t                r_state;
  logic                  r_id, r_fixed, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_len;
  logic [2:0]            r_size;
  logic [4:0]            r_cnt;
  logic                  w_aw, w_w, w_last;
  assign w_aw       = awvalid & awready;
  assign w_w        = wvalid & wready;
  assign w_last     = r_cnt == {1'b0, r_len};
  assign awready    = (r_state == IDLE) & eng_en;
  assign wready     = (r_state == DATA) & beat_ready;
  assign beat_valid = (r_state == DATA) & wvalid;
  assign beat_last  = (r_state == DATA) & w_last;
  assign beat_addr  = r_addr;
  assign beat_data  = wdata;
  assign beat_strb  = wstrb;
  assign bvalid     = r_state == RESP;
  assign bid        = bvalid & r_id;
  assign bresp      = {bvalid & r_err, 1'b0};
  assign busy       = r_state != IDLE;
  // unsupported burst types fall back to INCR addressing; only FIXED holds the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_aw) begin
          r_state <= DATA;
          r_id    <= awid;
          r_addr  <= awaddr;
          r_len   <= awlen;
          r_size  <= awsize;
          r_fixed <= awburst == 2'b00;
          r_cnt   <= '0;
          r_err   <= awburst[1] | (awsize > 3'(MAX_SIZE));
        end
        DATA: if (w_w) begin
          r_err <= r_err | beat_err | (wid != r_id) | (wlast != w_last);
          r_cnt <= r_cnt + 5'd1;
          if (!r_fixed) r_addr <= r_addr + (ADDR_WIDTH'(1) << r_size);
          if (w_last) r_state <= RESP;
        end
        RESP: if (bready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
